topk_sorted_cam: RTL

- Consumer of the min-count stream leaving the count-min sketch min-reduction stage. Each (addr, estimated count) result updates a K-entry CAM that is kept sorted by count, highest first, so the table always holds the current top-K hot addresses.
- A dump state machine streams the table out in rank order over a valid/ready handshake for host readout.
- Sits between the sketch min-reduction output and the CSR/readout logic of the sorted-CAM AFU.

---
 rtl/topk_sorted_cam.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/topk_sorted_cam.sv
`default_nettype none
// ============================================================================
// Module   : topk_sorted_cam
// Purpose  : K-entry CAM holding the top-K hot addresses, sorted by estimated
//            count (highest first). It consumes (addr, count) results from the
//            count-min sketch min-reduction stage. A dump FSM streams the table
//            out in rank order over a valid/ready handshake.
// Ports    : clk, rst_n (async, active low), query_rst_n (sync epoch clear)
//            in_valid/in_addr/in_cnt     - sketch results, no backpressure
//            dump_start                  - begin readout (IDLE only)
//            out_valid/out_ready/out_addr/out_cnt/out_rank/out_last - dump stream
//            dump_done (pulse), busy (in DUMP), num_valid, drop_cnt (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module topk_sorted_cam #(
   parameter int K         = 16,
   parameter int ADDR_SIZE = 22,
   parameter int CNT_SIZE  = 32,
   parameter int DROP_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   query_rst_n,
   input  logic                   in_valid,
   input  logic [ADDR_SIZE-1:0]   in_addr,
   input  logic [CNT_SIZE-1:0]    in_cnt,
   input  logic                   dump_start,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_SIZE-1:0]   out_addr,
   output logic [CNT_SIZE-1:0]    out_cnt,
   output logic [$clog2(K)-1:0]   out_rank,
   output logic                   out_last,
   output logic                   dump_done,
   output logic                   busy,
   output logic [$clog2(K):0]     num_valid,
   output logic [DROP_W-1:0]      drop_cnt
);

   localparam int RW = $clog2(K);
   localparam int NW = RW + 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_DUMP = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [K-1:0]          valid_q, valid_d;
   logic [ADDR_SIZE-1:0]  addr_q [K];
   logic [ADDR_SIZE-1:0]  addr_d [K];
   logic [CNT_SIZE-1:0]   cnt_q  [K];
   logic [CNT_SIZE-1:0]   cnt_d  [K];
   logic [NW-1:0]         num_valid_q, num_valid_d;
   logic [RW-1:0]         rank_q, rank_d;
   logic [DROP_W-1:0]     drop_q, drop_d;
   logic                  done_q, done_d;

   // Per-slot match terms. Because the table is sorted and contiguous, ge is a
   // prefix mask: ge[i] is set exactly for slots above the insertion point p.
   logic [K-1:0] hit;
   logic [K-1:0] ge;
   logic [K-1:0] hit_above;   // a hit lies strictly above slot i
   logic [K-1:0] take_new;    // slot i receives the incoming entry
   logic [K-1:0] take_up;     // slot i receives the entry from slot i-1
   logic         hit_any;
   logic         hit_fresh;
   logic         accept;
   logic         dump_last;

   assign hit_any   = |hit;
   // A hit whose stored count is below in_cnt; smaller-or-equal is stale.
   assign hit_fresh = |(hit & ~ge);
   // A miss with p == K (ge[K-1] set) falls off the bottom and is discarded.
   assign accept    = (state_q == ST_IDLE) && in_valid && (in_cnt != '0) &&
                      (hit_any ? hit_fresh : !ge[K-1]);

   generate
      for (genvar i = 0; i < K; i++) begin : g_slot
         assign hit[i] = valid_q[i] && (addr_q[i] == in_addr);
         assign ge[i]  = valid_q[i] && (cnt_q[i] >= in_cnt);

         if (i == 0) begin : g_head
            assign hit_above[i] = 1'b0;
            assign take_new[i]  = accept && !ge[0];
            assign take_up[i]   = 1'b0;
            assign valid_d[i]   = take_new[i] ? 1'b1    : valid_q[i];
            assign addr_d[i]    = take_new[i] ? in_addr : addr_q[i];
            assign cnt_d[i]     = take_new[i] ? in_cnt  : cnt_q[i];
         end else begin : g_body
            assign hit_above[i] = |hit[i-1:0];
            assign take_new[i]  = accept && !ge[i] && ge[i-1];
            // Shift window runs from p+1 down to the removed hit slot, or to
            // K-1 on a miss (which evicts the old bottom entry).
            assign take_up[i]   = accept && !ge[i] && !ge[i-1] && !hit_above[i];
            assign valid_d[i]   = take_new[i] ? 1'b1    :
                                  take_up[i]  ? valid_q[i-1] : valid_q[i];
            assign addr_d[i]    = take_new[i] ? in_addr :
                                  take_up[i]  ? addr_q[i-1]  : addr_q[i];
            assign cnt_d[i]     = take_new[i] ? in_cnt  :
                                  take_up[i]  ? cnt_q[i-1]   : cnt_q[i];
         end
      end
   endgenerate

   assign num_valid_d = (accept && !hit_any && !valid_q[K-1]) ?
                        num_valid_q + NW'(1) : num_valid_q;

   assign dump_last = ({1'b0, rank_q} == (num_valid_q - NW'(1)));

   // Dump FSM next state and counters
   always_comb begin
      state_d = state_q;
      rank_d  = rank_q;
      drop_d  = drop_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dump_start) begin
               state_d = ST_DUMP;
               rank_d  = '0;
            end
         end
         ST_DUMP: begin
            if (in_valid && (drop_q != '1)) begin
               drop_d = drop_q + DROP_W'(1);
            end
            if (num_valid_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (out_ready) begin
               if (dump_last) begin
                  state_d = ST_IDLE;
                  rank_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  rank_d = rank_q + RW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         valid_q     <= '0;
         num_valid_q <= '0;
         rank_q      <= '0;
         drop_q      <= '0;
         done_q      <= 1'b0;
         for (int i = 0; i < K; i++) begin
            addr_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else if (!query_rst_n) begin
         state_q     <= ST_IDLE;
         valid_q     <= '0;
         num_valid_q <= '0;
         rank_q      <= '0;
         drop_q      <= '0;
         done_q      <= 1'b0;
         for (int i = 0; i < K; i++) begin
            addr_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         num_valid_q <= num_valid_d;
         rank_q      <= rank_d;
         drop_q      <= drop_d;
         done_q      <= done_d;
         for (int i = 0; i < K; i++) begin
            addr_q[i] <= addr_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
      end
   end

   assign busy      = (state_q == ST_DUMP);
   assign out_valid = busy && (num_valid_q != '0);
   assign out_addr  = out_valid ? addr_q[rank_q] : '0;
   assign out_cnt   = out_valid ? cnt_q[rank_q]  : '0;
   assign out_rank  = out_valid ? rank_q         : '0;
   assign out_last  = out_valid && dump_last;
   assign dump_done = done_q;
   assign num_valid = num_valid_q;
   assign drop_cnt  = drop_q;

endmodule
`default_nettype wire
